// File: rtl/hazard_stall_ctrl.sv
// ID-stage interlock: holds PC/IF-ID and injects ID/EXE bubbles for hazards that forwarding cannot cover.
// Optional HZ_PERF_CNT_EN adds saturating bubble / memory-busy cycle counters.
module hazard_stall_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr,
  input  logic        UsesRt,
  input  logic        Branch,
  input  logic        FWD_REQ_FREEZE,
  input  logic        MemRead_EXE,
  input  logic [4:0]  DestReg_EXE,
  input  logic        MemRead_MEM,
  input  logic [4:0]  DestReg_MEM,
  input  logic        MEM_BUSY,
  output logic        FREEZE_IF_ID,
  output logic        BUBBLE_ID_EXE,
  output logic        PIPE_FREEZE,
  output logic        STALL_ACTIVE
`ifdef HZ_PERF_CNT_EN
  ,
  output logic [15:0] HZ_BUBBLE_CNT,
  output logic [15:0] HZ_BUSY_CNT
`endif
);

  typedef enum logic {RUN = 1'b0, HOLD1 = 1'b1} state_t;

  state_t     state;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       match_exe;
  logic       match_mem;
  logic       need2;
  logic       need1;
  logic       unused_instr_bits;

  // A zero destination never creates a dependency; rt only counts when the instruction reads it.
  function automatic logic src_match(input logic [4:0] s, input logic [4:0] t,
                                     input logic [4:0] d, input logic use_t);
    return (d != 5'd0) && ((s == d) || (use_t && (t == d)));
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign rs                = Instr[25:21];
  assign rt                = Instr[20:16];
  assign unused_instr_bits = ^{Instr[31:26], Instr[15:0]};

  assign match_exe = src_match(rs, rt, DestReg_EXE, UsesRt);
  assign match_mem = src_match(rs, rt, DestReg_MEM, UsesRt);

  // Branch on a load still in EXE needs two cycles; the one-cycle cases never stack with it.
  assign need2 = Branch & MemRead_EXE & match_exe;
  assign need1 = (FWD_REQ_FREEZE & ~need2)
               | (~Branch & MemRead_EXE & match_exe)
               | (Branch & MemRead_MEM & match_mem);

  always_comb begin
    FREEZE_IF_ID  = 1'b0;
    BUBBLE_ID_EXE = 1'b0;
    PIPE_FREEZE   = 1'b0;
    if (RESET) begin
      if (MEM_BUSY) begin
        PIPE_FREEZE  = 1'b1;
        FREEZE_IF_ID = 1'b1;
      end else if ((state == HOLD1) || need1 || need2) begin
        FREEZE_IF_ID  = 1'b1;
        BUBBLE_ID_EXE = 1'b1;
      end
    end
  end

  // Memory-busy cycles freeze the FSM so they never consume a pending bubble.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= RUN;
    end else if (!MEM_BUSY) begin
      if (state == HOLD1)
        state <= RUN;
      else if (need2)
        state <= HOLD1;
    end
  end

  assign STALL_ACTIVE = (state == HOLD1);

`ifdef HZ_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      HZ_BUBBLE_CNT <= 16'd0;
      HZ_BUSY_CNT   <= 16'd0;
    end else begin
      if (BUBBLE_ID_EXE)
        HZ_BUBBLE_CNT <= sat_inc(HZ_BUBBLE_CNT);
      if (MEM_BUSY)
        HZ_BUSY_CNT <= sat_inc(HZ_BUSY_CNT);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed hazard scenarios plus random traffic against a bubble-count model.
module tb_hazard_stall_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] Instr = 32'd0;
  logic        UsesRt = 1'b0;
  logic        Branch = 1'b0;
  logic        FWD_REQ_FREEZE = 1'b0;
  logic        MemRead_EXE = 1'b0;
  logic [4:0]  DestReg_EXE = 5'd0;
  logic        MemRead_MEM = 1'b0;
  logic [4:0]  DestReg_MEM = 5'd0;
  logic        MEM_BUSY = 1'b0;
  logic        FREEZE_IF_ID;
  logic        BUBBLE_ID_EXE;
  logic        PIPE_FREEZE;
  logic        STALL_ACTIVE;
`ifdef HZ_PERF_CNT_EN
  logic [15:0] HZ_BUBBLE_CNT;
  logic [15:0] HZ_BUSY_CNT;
  int          m_bub_cnt = 0;
  int          m_busy_cnt = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int pending  = 0;
  int bub_seen = 0;

  always #5 CLK = ~CLK;

  hazard_stall_ctrl dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .Instr          (Instr),
    .UsesRt         (UsesRt),
    .Branch         (Branch),
    .FWD_REQ_FREEZE (FWD_REQ_FREEZE),
    .MemRead_EXE    (MemRead_EXE),
    .DestReg_EXE    (DestReg_EXE),
    .MemRead_MEM    (MemRead_MEM),
    .DestReg_MEM    (DestReg_MEM),
    .MEM_BUSY       (MEM_BUSY),
    .FREEZE_IF_ID   (FREEZE_IF_ID),
    .BUBBLE_ID_EXE  (BUBBLE_ID_EXE),
    .PIPE_FREEZE    (PIPE_FREEZE),
    .STALL_ACTIVE   (STALL_ACTIVE)
`ifdef HZ_PERF_CNT_EN
    ,
    .HZ_BUBBLE_CNT  (HZ_BUBBLE_CNT),
    .HZ_BUSY_CNT    (HZ_BUSY_CNT)
`endif
  );

  function automatic logic [31:0] mk(input logic [4:0] s, input logic [4:0] t);
    return {6'd0, s, t, 16'd0};
  endfunction

  // Stall need (0/1/2 cycles) for the inputs currently applied.
  function automatic int need_of();
    int rs_i;
    int rt_i;
    bit hit_e;
    bit hit_m;
    rs_i  = int'(Instr[25:21]);
    rt_i  = int'(Instr[20:16]);
    hit_e = 0;
    hit_m = 0;
    if (DestReg_EXE != 0 && (rs_i == DestReg_EXE || (UsesRt && rt_i == DestReg_EXE))) hit_e = 1;
    if (DestReg_MEM != 0 && (rs_i == DestReg_MEM || (UsesRt && rt_i == DestReg_MEM))) hit_m = 1;
    if (Branch && MemRead_EXE && hit_e) return 2;
    if (FWD_REQ_FREEZE || (!Branch && MemRead_EXE && hit_e) || (Branch && MemRead_MEM && hit_m)) return 1;
    return 0;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    Instr = 32'd0; UsesRt = 0; Branch = 0; FWD_REQ_FREEZE = 0;
    MemRead_EXE = 0; DestReg_EXE = 0; MemRead_MEM = 0; DestReg_MEM = 0; MEM_BUSY = 0;
  endtask

  // Entered just after a falling edge with inputs applied; leaves at the next falling edge.
  task automatic cycle();
    int   n;
    logic e_frz, e_bub, e_pipe, e_sa;
    #1;
    n      = need_of();
    e_frz  = 0; e_bub = 0; e_pipe = 0;
    e_sa   = (pending > 0);
    if (!RESET) begin
      e_sa = 0;
    end else if (MEM_BUSY) begin
      e_pipe = 1; e_frz = 1;
    end else if (pending > 0 || n > 0) begin
      e_frz = 1; e_bub = 1;
    end
    check("FREEZE_IF_ID", FREEZE_IF_ID, e_frz);
    check("BUBBLE_ID_EXE", BUBBLE_ID_EXE, e_bub);
    check("PIPE_FREEZE", PIPE_FREEZE, e_pipe);
    check("STALL_ACTIVE", STALL_ACTIVE, e_sa);
    if (BUBBLE_ID_EXE === 1'b1) bub_seen++;
    @(posedge CLK);
    if (!RESET) begin
      pending = 0;
`ifdef HZ_PERF_CNT_EN
      m_bub_cnt = 0; m_busy_cnt = 0;
`endif
    end else begin
`ifdef HZ_PERF_CNT_EN
      if (e_bub && m_bub_cnt < 65535) m_bub_cnt++;
      if (MEM_BUSY && m_busy_cnt < 65535) m_busy_cnt++;
`endif
      if (!MEM_BUSY) begin
        if (pending > 0) pending--;
        else if (n == 2) pending = 1;
      end
    end
    @(negedge CLK);
`ifdef HZ_PERF_CNT_EN
    check_int("HZ_BUBBLE_CNT", int'(HZ_BUBBLE_CNT), m_bub_cnt);
    check_int("HZ_BUSY_CNT", int'(HZ_BUSY_CNT), m_busy_cnt);
`endif
  endtask

  initial begin
    // Reset held low with every hazard input asserted: outputs must stay quiet.
    RESET = 0;
    Instr = mk(5'd2, 5'd0); UsesRt = 1; Branch = 1; FWD_REQ_FREEZE = 1;
    MemRead_EXE = 1; DestReg_EXE = 5'd2; MemRead_MEM = 1; DestReg_MEM = 5'd2; MEM_BUSY = 1;
    @(negedge CLK);
    cycle();
    MEM_BUSY = 0;
    cycle();
    RESET = 1;
    idle();
    cycle();

    // Load-use: lw $3 in EXE, add $5,$3,$4 in ID.
    bub_seen = 0;
    Instr = mk(5'd3, 5'd4); UsesRt = 1; MemRead_EXE = 1; DestReg_EXE = 5'd3;
    cycle();
    MemRead_EXE = 0; DestReg_EXE = 0; MemRead_MEM = 1; DestReg_MEM = 5'd3;
    cycle();
    idle();
    cycle();
    check_int("loaduse_total", bub_seen, 1);

    // Branch on load in EXE: beq $2,$0 waits two cycles.
    bub_seen = 0;
    Instr = mk(5'd2, 5'd0); UsesRt = 1; Branch = 1; MemRead_EXE = 1; DestReg_EXE = 5'd2;
    cycle();
    MemRead_EXE = 0; DestReg_EXE = 0; MemRead_MEM = 1; DestReg_MEM = 5'd2;
    cycle();
    idle();
    cycle();
    Instr = mk(5'd2, 5'd6); UsesRt = 1;
    cycle();
    check_int("brload_total", bub_seen, 2);

    // Branch on ALU result, then load to $0 (no dependency).
    bub_seen = 0;
    idle();
    Instr = mk(5'd7, 5'd0); Branch = 1; FWD_REQ_FREEZE = 1;
    cycle();
    idle();
    cycle();
    Instr = mk(5'd0, 5'd0); UsesRt = 1; MemRead_EXE = 1; DestReg_EXE = 5'd0;
    cycle();
    check_int("bralu_total", bub_seen, 1);

    // MEM_BUSY for three cycles in the middle of the two-cycle stall.
    bub_seen = 0;
    idle();
    Instr = mk(5'd4, 5'd0); UsesRt = 1; Branch = 1; MemRead_EXE = 1; DestReg_EXE = 5'd4;
    cycle();
    MemRead_EXE = 0; DestReg_EXE = 0; MemRead_MEM = 1; DestReg_MEM = 5'd4; MEM_BUSY = 1;
    repeat (3) cycle();
    MEM_BUSY = 0;
    cycle();
    idle();
    cycle();
    check_int("busy_hold_total", bub_seen, 2);

    // Asynchronous reset pulse while in the second stall cycle.
    idle();
    Instr = mk(5'd2, 5'd0); UsesRt = 1; Branch = 1; MemRead_EXE = 1; DestReg_EXE = 5'd2;
    cycle();
    MemRead_EXE = 0; DestReg_EXE = 0; MemRead_MEM = 1; DestReg_MEM = 5'd2;
    #1;
    check("pre_reset_STALL_ACTIVE", STALL_ACTIVE, 1'b1);
    RESET = 0;
    #1;
    check("arst_FREEZE_IF_ID", FREEZE_IF_ID, 1'b0);
    check("arst_BUBBLE_ID_EXE", BUBBLE_ID_EXE, 1'b0);
    check("arst_PIPE_FREEZE", PIPE_FREEZE, 1'b0);
    check("arst_STALL_ACTIVE", STALL_ACTIVE, 1'b0);
    pending = 0;
`ifdef HZ_PERF_CNT_EN
    m_bub_cnt = 0; m_busy_cnt = 0;
`endif
    #1;
    RESET = 1;
    idle();
    cycle();
    cycle();

    // Random traffic with small register numbers so dependencies are frequent.
    for (int i = 0; i < 400; i++) begin
      Instr          = $urandom;
      Instr[25:21]   = 5'($urandom_range(0, 3));
      Instr[20:16]   = 5'($urandom_range(0, 3));
      UsesRt         = 1'($urandom_range(0, 1));
      Branch         = 1'($urandom_range(0, 1));
      FWD_REQ_FREEZE = ($urandom_range(0, 5) == 0);
      MemRead_EXE    = 1'($urandom_range(0, 1));
      DestReg_EXE    = 5'($urandom_range(0, 3));
      MemRead_MEM    = 1'($urandom_range(0, 1));
      DestReg_MEM    = 5'($urandom_range(0, 3));
      MEM_BUSY       = ($urandom_range(0, 4) == 0);
      RESET          = ($urandom_range(0, 49) != 0);
      cycle();
    end
    RESET = 1;
    idle();
    cycle();

`ifdef HZ_PERF_CNT_EN
    // Saturation of the bubble counter under a permanently asserted one-cycle hazard.
    RESET = 0;
    #1;
    RESET = 1;
    FWD_REQ_FREEZE = 1;
    repeat (70000) @(posedge CLK);
    @(negedge CLK);
    check_int("bubble_cnt_sat", int'(HZ_BUBBLE_CNT), 65535);
    check_int("busy_cnt_idle", int'(HZ_BUSY_CNT), 0);
    idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline interlock controller in the ID stage. Consumes the branch-compare freeze request from the forwarding unit and the load destination info from ID/EXE and EXE/MEM. Resolves every hazard that forwarding cannot cover: load-use, branch-on-ALU-result and branch-on-load. Holds PC and IF/ID, and injects NOP bubbles into ID/EXE for the exact number of cycles each hazard needs; a memory-busy condition freezes the whole pipeline.

## Interface
- No parameters.
- CLK  input  1  pipeline clock, all state on rising edge
- RESET  input  1  asynchronous, active-low reset
- Instr  input  32  instruction in ID; rs = [25:21], rt = [20:16]
- UsesRt  input  1  ID instruction reads rt (R-type, store, BEQ/BNE)
- Branch  input  1  ID instruction is a branch/JR (compare in ID)
- FWD_REQ_FREEZE  input  1  forwarding unit: branch depends on the instruction now in EXE
- MemRead_EXE  input  1  instruction in EXE is a load
- DestReg_EXE  input  5  destination of instruction in EXE (0 = none)
- MemRead_MEM  input  1  instruction in MEM is a load
- DestReg_MEM  input  5  destination of instruction in MEM (0 = none)
- MEM_BUSY  input  1  data memory not ready; whole pipeline must hold
- FREEZE_IF_ID  output  1  hold PC and IF/ID register
- BUBBLE_ID_EXE  output  1  load NOP into ID/EXE instead of decoded instruction
- PIPE_FREEZE  output  1  hold every pipeline register (ID/EXE, EXE/MEM, MEM/WB)
- STALL_ACTIVE  output  1  registered: controller is in a forced-stall state

## Operation
- A source matches a destination only if the destination is nonzero. rt participates only when UsesRt=1.
- Hazard need N, evaluated in state RUN:
  - N=2: Branch & MemRead_EXE & src matches DestReg_EXE.
  - N=1: FWD_REQ_FREEZE & not the N=2 case; or !Branch & MemRead_EXE & src match; or Branch & MemRead_MEM & src matches DestReg_MEM.
  - N=0: otherwise.
- FSM states: RUN, HOLD1.
  - RUN, N=0: all stall outputs 0.
  - RUN, N≥1: FREEZE_IF_ID=1 and BUBBLE_ID_EXE=1 this cycle. If N=2, next state is HOLD1; if N=1, stay in RUN and re-evaluate next cycle. The producer has advanced by then, so the hazard is cleared.
  - HOLD1: FREEZE_IF_ID=1 and BUBBLE_ID_EXE=1 unconditionally; next state is RUN.
- MEM_BUSY=1 overrides everything:
  - PIPE_FREEZE=1, FREEZE_IF_ID=1, BUBBLE_ID_EXE=0.
  - The FSM holds its state: no transition, no count consumed.
  - The stall resumes when MEM_BUSY falls.
- FREEZE_IF_ID, BUBBLE_ID_EXE and PIPE_FREEZE are combinational from the state and inputs. STALL_ACTIVE is high when state=HOLD1 (registered state bit).

## Timing
- Reset (RESET low, asynchronous): state=RUN. All outputs 0 regardless of other inputs while RESET is low.
- Stall latency is zero: outputs respond in the same cycle the dependent instruction sits in ID.
- Total stall cycles (MEM_BUSY=0): load-use = 1, branch-on-ALU = 1, branch-on-load-in-MEM = 1, branch-on-load-in-EXE = 2.
- The stall count is independent of MEM_BUSY stretching: busy cycles add to wall time but never to the bubble count.
- Reset asserted in HOLD1 causes an immediate return to RUN; no residual bubble after release.
- A hazard on both rs and rt counts once. The largest N wins.

## Configuration
- HZ_PERF_CNT_EN: when defined, adds two 16-bit outputs:
  - HZ_BUBBLE_CNT counts cycles with BUBBLE_ID_EXE=1.
  - HZ_BUSY_CNT counts cycles with MEM_BUSY=1.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

## Test plan
- Load-use: lw $3 in EXE, add $5,$3,$4 in ID (UsesRt=1) -> exactly 1 cycle of FREEZE_IF_ID=1 and BUBBLE_ID_EXE=1, then 0; STALL_ACTIVE stays 0.
- Branch on load: lw $2 in EXE, beq $2,$0 in ID -> 2 consecutive bubble cycles; STALL_ACTIVE=1 in the second cycle; add follows with no stall.
- Branch on ALU result: FWD_REQ_FREEZE=1 with MemRead_EXE=0 -> 1 bubble cycle. Destination $0 with MemRead_EXE=1 -> no stall.
- MEM_BUSY=1 for 3 cycles during HOLD1 -> PIPE_FREEZE=1 and BUBBLE_ID_EXE=0 for 3 cycles, then one bubble cycle, then RUN; total bubbles = 2.
- Async reset pulsed mid-HOLD1 (between clock edges) -> all outputs 0 immediately; after release with no hazard, outputs stay 0.
- With HZ_PERF_CNT_EN: 70000 forced bubble cycles -> HZ_BUBBLE_CNT saturates at 65535.
